// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants and the transmit framer state encoding.
package eth_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        IDLE,
        PRE,
        SFD,
        DATA,
        PAD,
        FCS,
        IFG,
        DROP
    } tx_state_t;

endpackage

// File: rtl/crc32_d8.sv
// Combinational reflected CRC-32 update for one byte; shared with the receive-side checker.
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        // NOTE: c gets a full value before the loop so no path leaves it unassigned (no latch).
        c = crc_in ^ {24'h000000, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ({1'b0, c[31:1]} ^ CRC32_POLY) : {1'b0, c[31:1]};
        end
        crc_out = c;
    end

endmodule

// File: rtl/gmii_tx_framer.sv
// Byte-stream to GMII transmit framer: preamble/SFD, data, zero pad, CRC-32 FCS, inter-frame gap.
module gmii_tx_framer
    import eth_pkg::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_DATA_LEN = 60,
    parameter int IFG_CYCLES   = 12
) (
    input  logic       rgmii_125m,
    input  logic       reset,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] gmii_txd_o,
    output logic       gmii_tx_en_o,
    output logic       tx_busy,
    output logic       underrun
);

    // IDLE already launches the first preamble byte, so PRE covers the remaining ones.
    localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_LEN - 2);
    localparam logic [7:0]  IFG_LAST = 8'(IFG_CYCLES - 1);
    localparam logic [16:0] MIN_LEN  = 17'(MIN_DATA_LEN);

    tx_state_t   state;
    logic [7:0]  phase_cnt;
    logic [15:0] byte_cnt;
    logic [31:0] crc;
    logic        bad_fcs;
    logic        drop_pending;

    logic [31:0] crc_next;
    logic [7:0]  crc_byte;
    logic [16:0] byte_cnt_inc;
    logic [15:0] byte_cnt_sat;
    logic [31:0] fcs_word;

    assign crc_byte     = (state == DATA) ? s_data : 8'h00;
    assign byte_cnt_inc = {1'b0, byte_cnt} + 17'd1;
    assign byte_cnt_sat = (&byte_cnt) ? byte_cnt : byte_cnt + 16'd1;
    assign fcs_word     = bad_fcs ? crc : ~crc;

    assign s_ready = (state == DATA) || (state == DROP);
    assign tx_busy = (state != IDLE);

    crc32_d8 u_crc (
        .crc_in  (crc),
        .data    (crc_byte),
        .crc_out (crc_next)
    );

    // NOTE: all state and registered outputs use non-blocking assignments so every
    // decision in this block sees the values from before the edge.
    always_ff @(posedge rgmii_125m) begin
        if (reset) begin
            state        <= IDLE;
            phase_cnt    <= 8'd0;
            byte_cnt     <= 16'd0;
            crc          <= CRC32_INIT;
            bad_fcs      <= 1'b0;
            drop_pending <= 1'b0;
            gmii_txd_o   <= 8'h00;
            gmii_tx_en_o <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            gmii_txd_o   <= 8'h00;
            gmii_tx_en_o <= 1'b0;
            underrun     <= 1'b0;

            case (state)
                IDLE: begin
                    if (drop_pending) begin
                        state <= DROP;
                    end else if (s_valid) begin
                        gmii_txd_o   <= PREAMBLE_BYTE;
                        gmii_tx_en_o <= 1'b1;
                        phase_cnt    <= 8'd0;
                        state        <= PRE;
                    end
                end

                PRE: begin
                    gmii_txd_o   <= PREAMBLE_BYTE;
                    gmii_tx_en_o <= 1'b1;
                    if (phase_cnt == PRE_LAST) begin
                        state <= SFD;
                    end else begin
                        phase_cnt <= phase_cnt + 8'd1;
                    end
                end

                SFD: begin
                    gmii_txd_o   <= SFD_BYTE;
                    gmii_tx_en_o <= 1'b1;
                    crc          <= CRC32_INIT;
                    byte_cnt     <= 16'd0;
                    state        <= DATA;
                end

                DATA: begin
                    phase_cnt <= 8'd0;
                    if (s_valid) begin
                        gmii_txd_o   <= s_data;
                        gmii_tx_en_o <= 1'b1;
                        crc          <= crc_next;
                        byte_cnt     <= byte_cnt_sat;
                        if (s_last) begin
                            state <= (byte_cnt_inc < MIN_LEN) ? PAD : FCS;
                        end
                    end else begin
                        // Source starved mid-frame: close with a deliberately wrong FCS.
                        underrun     <= 1'b1;
                        bad_fcs      <= 1'b1;
                        drop_pending <= 1'b1;
                        state        <= FCS;
                    end
                end

                PAD: begin
                    gmii_txd_o   <= 8'h00;
                    gmii_tx_en_o <= 1'b1;
                    crc          <= crc_next;
                    byte_cnt     <= byte_cnt_sat;
                    phase_cnt    <= 8'd0;
                    if (byte_cnt_inc >= MIN_LEN) begin
                        state <= FCS;
                    end
                end

                FCS: begin
                    gmii_txd_o   <= fcs_word[{phase_cnt[1:0], 3'b000} +: 8];
                    gmii_tx_en_o <= 1'b1;
                    if (phase_cnt == 8'd3) begin
                        bad_fcs   <= 1'b0;
                        phase_cnt <= 8'd0;
                        state     <= IFG;
                    end else begin
                        phase_cnt <= phase_cnt + 8'd1;
                    end
                end

                IFG: begin
                    if (phase_cnt == IFG_LAST) begin
                        state <= IDLE;
                    end else begin
                        phase_cnt <= phase_cnt + 8'd1;
                    end
                end

                DROP: begin
                    if (s_valid && s_last) begin
                        drop_pending <= 1'b0;
                        state        <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
